// File: rtl/m31_poseidon2_sponge_ctrl_if.sv
// Stream-side bundle of the M31 Poseidon2 sponge controller: element input,
// digest output and busy status.
interface m31_poseidon2_sponge_ctrl_if #(
    parameter int unsigned DIGEST_LEN = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic [30:0]               in_data;
    logic                      in_last;
    logic                      out_valid;
    logic                      out_ready;
    logic [DIGEST_LEN*31-1:0]  out_data;
    logic                      busy;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/m31_poseidon2_sponge_ctrl.sv
// Sponge controller for the M31 Poseidon2 permutation: absorbs elements into the
// rate lanes, times the fixed-latency permutation, and presents the digest.
module m31_poseidon2_sponge_ctrl #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned RATE         = 8,
    parameter int unsigned DIGEST_LEN   = 8,
    parameter int unsigned PERM_LATENCY = 23
) (
    input  logic                         clk,
    input  logic                         rst_n,
    m31_poseidon2_sponge_ctrl_if.slave   stream,
    output logic [WIDTH*31-1:0]          perm_state_o,
    input  logic [WIDTH*31-1:0]          perm_state_i
);

    localparam logic [30:0] P     = 31'h7FFF_FFFF;
    localparam int unsigned IDX_W = (RATE > 1) ? $clog2(RATE) : 1;
    localparam int unsigned CNT_W = $clog2(PERM_LATENCY + 1);

    typedef enum logic [1:0] {
        ST_ABSORB,
        ST_WAIT,
        ST_SQUEEZE
    } fsm_e;

    fsm_e                      fsm_q,   fsm_d;
    logic [WIDTH-1:0][30:0]    state_q, state_d;
    logic [IDX_W-1:0]          idx_q,   idx_d;
    logic [CNT_W-1:0]          cnt_q,   cnt_d;
    logic                      final_q, final_d;

    logic [30:0]               elem;

    // Operands are canonical, so a single end-around carry folds the sum back below 2p.
    function automatic logic [30:0] madd(input logic [30:0] a, input logic [30:0] b);
        logic [31:0] s;
        logic [30:0] f;
        s = {1'b0, a} + {1'b0, b};
        f = s[30:0] + {30'd0, s[31]};
        return (f == P) ? '0 : f;
    endfunction

    assign elem = (stream.in_data == P) ? '0 : stream.in_data;

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        final_d = final_q;

        case (fsm_q)
            ST_ABSORB: begin
                if (stream.in_valid) begin
                    for (int unsigned i = 0; i < RATE; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            state_d[i] = madd(state_q[i], elem);
                        end
                    end
                    if ((idx_q == IDX_W'(RATE - 1)) || stream.in_last) begin
                        fsm_d   = ST_WAIT;
                        idx_d   = '0;
                        cnt_d   = '0;
                        final_d = stream.in_last;
                        if (stream.in_last) begin
                            state_d[RATE] = madd(state_q[RATE], 31'd1);
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(PERM_LATENCY)) begin
                    state_d = perm_state_i;
                    cnt_d   = '0;
                    fsm_d   = final_q ? ST_SQUEEZE : ST_ABSORB;
                end
            end

            ST_SQUEEZE: begin
                if (stream.out_ready) begin
                    state_d = '0;
                    final_d = 1'b0;
                    fsm_d   = ST_ABSORB;
                end
            end

            default: begin
                fsm_d = ST_ABSORB;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= ST_ABSORB;
            state_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            final_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            final_q <= final_d;
        end
    end

    // Handshake outputs depend only on FSM state; rst_n gating keeps them low during reset.
    assign stream.in_ready  = rst_n && (fsm_q == ST_ABSORB);
    assign stream.out_valid = rst_n && (fsm_q == ST_SQUEEZE);
    assign stream.busy      = rst_n && ((fsm_q == ST_WAIT) || (fsm_q == ST_SQUEEZE));
    assign stream.out_data  = state_q[DIGEST_LEN-1:0];
    assign perm_state_o     = state_q;

endmodule

// File: tb/tb_m31_poseidon2_sponge_ctrl.sv
// Self-checking bench for m31_poseidon2_sponge_ctrl with an identity delay-line
// permutation stub and a queue-based sponge reference model.
module tb_m31_poseidon2_sponge_ctrl;

    localparam int unsigned WIDTH        = 16;
    localparam int unsigned RATE         = 8;
    localparam int unsigned DIGEST_LEN   = 8;
    localparam int unsigned PERM_LATENCY = 23;
    localparam logic [30:0] P            = 31'h7FFF_FFFF;
    localparam longint      PL           = 64'h7FFF_FFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    m31_poseidon2_sponge_ctrl_if #(.DIGEST_LEN(DIGEST_LEN)) sif ();

    logic [WIDTH*31-1:0] perm_o;
    logic [WIDTH*31-1:0] perm_i;
    logic [WIDTH*31-1:0] pipe [PERM_LATENCY];

    // Identity permutation with the pipeline's latency; deliberately not reset.
    always @(posedge clk) begin
        pipe[0] <= perm_o;
        for (int i = 1; i < int'(PERM_LATENCY); i++) pipe[i] <= pipe[i-1];
    end
    assign perm_i = pipe[PERM_LATENCY-1];

    m31_poseidon2_sponge_ctrl #(
        .WIDTH(WIDTH),
        .RATE(RATE),
        .DIGEST_LEN(DIGEST_LEN),
        .PERM_LATENCY(PERM_LATENCY)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stream(sif),
        .perm_state_o(perm_o),
        .perm_state_i(perm_i)
    );

    typedef struct {
        string                      name;
        int unsigned                len;
        logic [9:0][30:0]           msg;
        logic [DIGEST_LEN-1:0][30:0] exp;
    } vec_t;

    vec_t tv[6];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Sponge with identity permutation: element k lands in rate lane k mod RATE.
    function automatic logic [DIGEST_LEN*31-1:0] ref_digest(input logic [30:0] m[$]);
        longint st[WIDTH];
        logic [DIGEST_LEN*31-1:0] r;
        for (int i = 0; i < int'(WIDTH); i++) st[i] = 0;
        for (int k = 0; k < m.size(); k++) begin
            longint v = (m[k] == P) ? 0 : longint'(m[k]);
            st[k % RATE] = (st[k % RATE] + v) % PL;
        end
        st[RATE] = (st[RATE] + 1) % PL;
        r = '0;
        for (int i = 0; i < int'(DIGEST_LEN); i++) r[i*31 +: 31] = 31'(st[i]);
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the beat transferred.
    task automatic send_beat(input logic [30:0] d, input logic l, output int acyc);
        int unsigned n = 0;
        sif.in_valid = 1'b1;
        sif.in_data  = d;
        sif.in_last  = l;
        while (!sif.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!sif.in_ready) begin
            fail_timeout("in_ready");
            sif.in_valid = 1'b0;
            acyc = -1;
            return;
        end
        acyc = cyc;
        @(negedge clk);
        sif.in_valid = 1'b0;
        sif.in_last  = 1'b0;
    endtask

    task automatic get_digest(input string name, input logic [DIGEST_LEN*31-1:0] exp,
                              input int unsigned hold, output int vcyc);
        int unsigned n = 0;
        while (!sif.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!sif.out_valid) begin
            fail_timeout(name);
            vcyc = -1;
            return;
        end
        vcyc = cyc;
        for (int unsigned h = 0; h < hold; h++) begin
            sif.in_valid = 1'b1;
            sif.in_data  = 31'($urandom % 32'h7FFF_FFFF);
            sif.in_last  = 1'($urandom);
            @(negedge clk);
            chk({name, "_bp_ctl"}, {sif.out_valid, sif.busy, sif.in_ready}, 3'b110);
            chk({name, "_bp_data"}, sif.out_data, exp);
        end
        sif.in_valid = 1'b0;
        sif.in_last  = 1'b0;
        chk(name, sif.out_data, exp);
        sif.out_ready = 1'b1;
        @(negedge clk);
        sif.out_ready = 1'b0;
        if (hold > 0) chk({name, "_post_hs"}, {sif.out_valid, sif.busy, sif.in_ready}, 3'b001);
    endtask

    task automatic send_msg(input logic [30:0] m[$], input bit gaps);
        int a;
        for (int k = 0; k < m.size(); k++) begin
            if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
            send_beat(m[k], k == m.size() - 1, a);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0][30:0] ep;
        logic [30:0] m[$];
        int a, vc, n;

        sif.in_valid = 1'b0; sif.in_data = '0; sif.in_last = 1'b0; sif.out_ready = 1'b0;

        // Table: single element, two blocks, exact block, modular wrap, 0x7FFFFFFF as 0.
        foreach (tv[t]) begin tv[t].msg = '0; tv[t].exp = '0; end
        tv[0].name = "tv_single";  tv[0].len = 1; tv[0].msg[0] = 31'd5; tv[0].exp[0] = 31'd5;
        tv[1].name = "tv_two_blk"; tv[1].len = 9;
        for (int i = 0; i < 9; i++) tv[1].msg[i] = 31'(i + 1);
        tv[1].exp[0] = 31'd10;
        for (int i = 1; i < 8; i++) tv[1].exp[i] = 31'(i + 1);
        tv[2].name = "tv_exact";   tv[2].len = 8;
        for (int i = 0; i < 8; i++) begin tv[2].msg[i] = 31'(i + 1); tv[2].exp[i] = 31'(i + 1); end
        tv[3].name = "tv_wrap";    tv[3].len = 9;
        for (int i = 0; i < 8; i++) begin tv[3].msg[i] = 31'h7FFF_FFFE; tv[3].exp[i] = 31'h7FFF_FFFE; end
        tv[3].msg[8] = 31'd3; tv[3].exp[0] = 31'd2;
        tv[4].name = "tv_pval";    tv[4].len = 3;
        tv[4].msg[0] = 31'd4; tv[4].msg[1] = P; tv[4].msg[2] = 31'd6;
        tv[4].exp[0] = 31'd4; tv[4].exp[2] = 31'd6;
        tv[5].name = "tv_zero";    tv[5].len = 3;
        tv[5].msg[0] = 31'd4; tv[5].msg[1] = 31'd0; tv[5].msg[2] = 31'd6;
        tv[5].exp[0] = 31'd4; tv[5].exp[2] = 31'd6;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            sif.in_valid = 1'($urandom); sif.in_data = 31'($urandom % 32'h7FFF_FFFF);
            sif.in_last = 1'($urandom); sif.out_ready = 1'($urandom);
            @(negedge clk);
        end
        chk("rst_ctl", {sif.in_ready, sif.out_valid, sif.busy}, 3'b000);
        chk("rst_perm", perm_o, '0);
        chk("rst_out", sif.out_data, '0);
        sif.in_valid = 1'b0; sif.in_last = 1'b0; sif.out_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", sif.in_ready, 1'b1);

        // Single element: WAIT contents and digest latency
        send_beat(31'd5, 1'b1, a);
        ep = '0; ep[0] = 31'd5; ep[RATE] = 31'd1;
        chk("single_wait_perm", perm_o, ep);
        chk("single_busy", {sif.busy, sif.in_ready}, 2'b10);
        m = {31'd5};
        get_digest("single_digest", ref_digest(m), 0, vc);
        chk("single_latency", 32'(vc), 32'(a + 25));

        // Two blocks: first WAIT contents and stall length
        m = {};
        for (int i = 1; i <= 8; i++) m.push_back(31'(i));
        for (int k = 0; k < 8; k++) send_beat(m[k], 1'b0, a);
        ep = '0;
        for (int i = 0; i < 8; i++) ep[i] = 31'(i + 1);
        chk("two_wait_perm", perm_o, ep);
        n = 0;
        while (!sif.in_ready && n < 100) begin @(negedge clk); n++; end
        chk("two_stall_len", 32'(n), 32'd24);
        m.push_back(31'd9);
        send_beat(31'd9, 1'b1, a);
        get_digest("two_digest", ref_digest(m), 0, vc);

        // Table vectors
        foreach (tv[t]) begin
            m = {};
            for (int k = 0; k < int'(tv[t].len); k++) m.push_back(tv[t].msg[k]);
            send_msg(m, 1'b0);
            get_digest(tv[t].name, tv[t].exp, 0, vc);
        end

        // Digest backpressure, then a fresh message
        m = {31'd11, 31'd22};
        send_msg(m, 1'b0);
        get_digest("bp_digest", ref_digest(m), 10, vc);
        m = {31'd3};
        send_msg(m, 1'b0);
        get_digest("bp_fresh", ref_digest(m), 0, vc);

        // Reset in the middle of WAIT; stale pipeline output must be ignored
        send_beat(31'd100, 1'b1, a);
        while (cyc < a + 10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ctl", {sif.in_ready, sif.out_valid, sif.busy}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", {sif.in_ready, sif.busy}, 2'b10);
        while (cyc < a + 30) begin
            chk("midrst_perm_zero", perm_o, '0);
            @(negedge clk);
        end
        m = {31'd7};
        send_msg(m, 1'b0);
        get_digest("midrst_digest", ref_digest(m), 0, vc);

        // Random messages against the reference model
        for (int r = 0; r < 30; r++) begin
            int unsigned len = $urandom_range(1, 20);
            m = {};
            for (int k = 0; k < int'(len); k++) begin
                case ($urandom_range(0, 9))
                    0:       m.push_back(P);
                    1:       m.push_back(31'h7FFF_FFFE);
                    2:       m.push_back(31'd0);
                    default: m.push_back(31'($urandom % 32'h7FFF_FFFF));
                endcase
            end
            send_msg(m, 1'b1);
            get_digest("rand_digest", ref_digest(m), $urandom_range(0, 3), vc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/m31_poseidon2_sponge_ctrl.md
# m31_poseidon2_sponge_ctrl

Sponge-mode hashing controller that sits directly upstream of the M31 Poseidon2 permutation pipeline and also consumes its output. It absorbs a valid/ready stream of M31 elements into the rate lanes by modular addition and issues each full or final block to the pipeline. The pipeline has no valid signal, so the controller tracks the in-flight permutation with a fixed-latency counter and captures the result. After the final block it presents a DIGEST_LEN-element digest on a valid/ready output.

## Interface
- WIDTH, 16, permutation state width in M31 lanes (multiple of 4)
- RATE, 8, rate lanes 0..RATE-1; capacity lanes RATE..WIDTH-1 (1 ≤ RATE < WIDTH)
- DIGEST_LEN, 8, digest lanes 0..DIGEST_LEN-1 (DIGEST_LEN ≤ RATE)
- PERM_LATENCY, 23, clock edges from permutation input to output (1 pre-MDS + 4 + 14 + 4 rounds)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  input element valid
- in_ready  out  1  controller accepts an element
- in_data  in  31  M31 element
- in_last  in  1  final element of the message
- perm_state_o  out  WIDTH×31  permutation pipeline input, lane i at bits [31i+30:31i]
- perm_state_i  in  WIDTH×31  permutation pipeline output
- out_valid  out  1  digest valid
- out_ready  in  1  digest consumer ready
- out_data  out  DIGEST_LEN×31  digest, lane i = state lane i
- busy  out  1  high in WAIT and SQUEEZE

## Operation
- Registers: state[WIDTH] (M31), lane index idx (0..RATE-1), final flag, latency counter cnt, FSM {ABSORB, WAIT, SQUEEZE}.
- perm_state_o = state register, continuously.
- Element canonicalisation: an in_data of 0x7FFFFFFF is treated as 0. Other values are taken as given and are < p.
- Addition mod p (p = 2^31−1): s = a + b (32 bit); f = s[30:0] + s[31]; result 0 if f == p. Results are always canonical.
- ABSORB: in_ready = 1. On an accepted beat:
  - state[idx] ← state[idx] + in_data.
  - If idx == RATE−1 or in_last: go to WAIT, idx ← 0, cnt ← 0, final ← in_last.
  - If in_last, additionally state[RATE] ← state[RATE] + 1 (domain separation), in the same edge.
  - Otherwise idx ← idx + 1.
  - Unwritten rate lanes of a partial final block keep their value (implicit zero padding).
- WAIT: in_ready = 0. cnt increments each cycle. At the edge ending the cycle with cnt == PERM_LATENCY:
  - state ← perm_state_i.
  - Next state is SQUEEZE if final, else ABSORB.
- SQUEEZE: out_valid = 1; out_data = state[0..DIGEST_LEN−1], stable while out_valid && !out_ready. On out_valid && out_ready:
  - state ← all zero, final ← 0, next state ABSORB.
- Only one permutation is in flight. Pipeline outputs outside the capture cycle are ignored.
- Reset (any state, including mid-WAIT): state all zero, FSM ABSORB, idx 0, cnt 0, final 0. Outputs: in_ready 0 during reset, out_valid 0, busy 0, out_data 0, perm_state_o 0. The in-flight permutation result is discarded.

## Timing
- Handshakes transfer on the rising edge where valid && ready. in_ready and out_valid depend only on FSM state, with no combinational path from in_valid or out_ready.
- in_ready is 1 in the first cycle after rst_n rises.
- If the block-completing beat is accepted in cycle A, then:
  - WAIT occupies cycles A+1..A+1+PERM_LATENCY.
  - in_ready returns in cycle A+PERM_LATENCY+2 for a non-final block.
  - out_valid asserts in cycle A+PERM_LATENCY+2 (A+25 at defaults) for a final block.
- Absorb throughput: RATE beats back-to-back, then a PERM_LATENCY+1 cycle stall.
- After the digest handshake in cycle D, in_ready is 1 in cycle D+1.
- in_valid is ignored outside ABSORB. out_ready is ignored outside SQUEEZE.

## Test plan
Bench permutation stub: a PERM_LATENCY-stage register delay line (identity).

- **Reset.** Hold rst_n low 3 cycles with random inputs → out_valid 0, busy 0, perm_state_o 0, in_ready 0. Cycle after release: in_ready 1.
- **Single-element message.** Send 5 with in_last in cycle A → during WAIT, perm_state_o lane0 = 5, lane8 = 1, other lanes 0. out_valid at A+25; out_data lane0 = 5, lanes 1..7 = 0.
- **Two blocks.** Send 1..8 (no last), then 9 with last.
  - First WAIT: perm_state_o lanes 0..7 = 1..8.
  - in_ready low exactly 24 cycles.
  - Digest lane0 = 10, lanes1..7 = 2..8.
- **Modular edges.**
  - Block of all 0x7FFFFFFE, then last beat 3 → lane0 = 2, lane8 = 1.
  - A message containing in_data 0x7FFFFFFF behaves identically to one with 0 in that position.
- **Digest backpressure.** Hold out_ready low 10 cycles after out_valid → out_valid, out_data and busy stable, and in_ready 0 with in_valid driven. On the handshake, in_ready is 1 next cycle and state is zeroed (the next message gives a fresh digest).
- **Reset mid-WAIT.** Assert rst_n low at cycle A+10 of a WAIT, release, then send message [7, last] → digest lane0 = 7, and the stale pipeline result is never captured.
